bin_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm, one bit per clock. It replaces the fixed 32-bit, 8-digit combinational divider chain in display and debug paths that need full-range conversion. It adds:
- valid/ready handshakes on input and output;
- an optional signed mode;
- an overflow flag when the digit count cannot hold the value.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_adj.sv | 10 +
 rtl/bin_to_bcd_seq.sv | 110 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Decimal digits needed to hold any w-bit unsigned value: ceil(w * log10(2)).
  function automatic int unsigned bcd_digits(input int unsigned w);
    longint unsigned scaled;
    scaled = 64'(w) * 64'd301029996 + 64'd999999999;
    return 32'(scaled / 64'd1000000000);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Largest result is 9 + 3 = 12, so four bits never overflow here.
  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes, optional signed input and a sticky overflow flag.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  sgn_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  overflow
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam int unsigned AccW = 4 * DIGITS;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]  mag_q, mag_d;
  logic [AccW-1:0]   acc_q, acc_d, acc_adj;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;
  logic              is_neg;
  logic              last_shift;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i(acc_q[4*i +: 4]),
      .digit_o(acc_adj[4*i +: 4])
    );
  end

  assign is_neg     = sgn_en && bin[BIN_W-1];
  // The counter tracks completed shifts; the final one lands on BIN_W-1.
  assign last_shift = (cnt_q == CntW'(BIN_W - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
          mag_d   = is_neg ? (~bin + BIN_W'(1)) : bin;
          neg_d   = is_neg;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // The bit leaving the top digit is a carry into a digit that does not exist.
        acc_d = {acc_adj[AccW-2:0], mag_q[BIN_W-1]};
        mag_d = {mag_q[BIN_W-2:0], 1'b0};
        ovf_d = ovf_q | acc_adj[AccW-1];
        cnt_d = cnt_q + CntW'(1);
        if (last_shift) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign bcd       = acc_q;
  assign neg       = neg_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench: three converter configurations, directed vectors plus an
// exhaustive 8-bit sweep against a decimal reference model.
module tb_bin_to_bcd_seq;
  import bcd_pkg::*;

  localparam int unsigned D0 = bcd_digits(32);
  localparam int unsigned D1 = 8;
  localparam int unsigned D2 = bcd_digits(8);

  typedef struct packed {
    logic        ov;
    logic        ordy;
    logic        irdy;
    logic [79:0] bcd;
    logic        neg;
    logic        ovf;
  } obs_t;

  typedef struct {
    logic [79:0] bcd;
    logic        neg;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
  logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;
  logic [31:0] b0 = '0, b1 = '0;
  logic [7:0]  b2 = '0;
  logic ir0, ir1, ir2, ov0, ov1, ov2, n0, n1, n2, f0, f1, f2;
  logic [4*D0-1:0] bcd0;
  logic [4*D1-1:0] bcd1;
  logic [4*D2-1:0] bcd2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic pv[3];

  bin_to_bcd_seq #(.BIN_W(32), .DIGITS(D0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .bin(b0), .sgn_en(s0),
    .out_valid(ov0), .out_ready(rdy0), .bcd(bcd0), .neg(n0), .overflow(f0)
  );
  bin_to_bcd_seq #(.BIN_W(32), .DIGITS(D1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .bin(b1), .sgn_en(s1),
    .out_valid(ov1), .out_ready(rdy1), .bcd(bcd1), .neg(n1), .overflow(f1)
  );
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(D2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .bin(b2), .sgn_en(s2),
    .out_valid(ov2), .out_ready(rdy2), .bcd(bcd2), .neg(n2), .overflow(f2)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial forever begin
    @(posedge clk);
    #1;
    rdy2 = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic obs_t get_obs(input int id);
    obs_t o;
    case (id)
      0: o = '{ov: ov0, ordy: rdy0, irdy: ir0, bcd: 80'(bcd0), neg: n0, ovf: f0};
      1: o = '{ov: ov1, ordy: rdy1, irdy: ir1, bcd: 80'(bcd1), neg: n1, ovf: f1};
      default: o = '{ov: ov2, ordy: rdy2, irdy: ir2, bcd: 80'(bcd2), neg: n2, ovf: f2};
    endcase
    return o;
  endfunction

  function automatic int bw(input int id);
    return (id == 2) ? 8 : 32;
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qfront(input int id);
    case (id)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpush(input int id, input exp_t e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int id);
    exp_t e;
    case (id)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic set_in(input int id, input logic v, input logic [63:0] b, input logic s);
    case (id)
      0: begin iv0 = v; b0 = b[31:0]; s0 = s; end
      1: begin iv1 = v; b1 = b[31:0]; s1 = s; end
      default: begin iv2 = v; b2 = b[7:0]; s2 = s; end
    endcase
  endtask

  function automatic logic [79:0] ref_bcd(input longint unsigned v, input int d);
    logic [79:0] r;
    r = '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send(input int id, input logic [63:0] b, input logic s,
                      input logic [79:0] eb, input logic en, input logic eo);
    int   n;
    obs_t o;
    exp_t e;
    set_in(id, 1'b1, b, s);
    n = 0;
    do begin
      @(negedge clk);
      o = get_obs(id);
      n++;
    end while (!o.irdy && n < 500);
    if (!o.irdy) begin
      check($sformatf("dut%0d accept timeout", id), 80'(o.irdy), 80'(1));
      set_in(id, 1'b0, '0, 1'b0);
      return;
    end
    @(posedge clk);
    #1;
    e.bcd = eb;
    e.neg = en;
    e.ovf = eo;
    e.acc = cyc;
    qpush(id, e);
    set_in(id, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_idle(input int id);
    int   n;
    obs_t o;
    n = 0;
    o = get_obs(id);
    while ((qsize(id) != 0 || o.ov) && n < 2000) begin
      @(negedge clk);
      o = get_obs(id);
      n++;
    end
    if (qsize(id) != 0) begin
      check($sformatf("dut%0d drain timeout", id), 80'(qsize(id)), 80'(0));
    end
  endtask

  // Monitor: compares every presented result against the head of its queue.
  initial begin
    for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    forever begin
      @(negedge clk);
      for (int id = 0; id < 3; id++) begin
        obs_t o;
        exp_t e;
        o = get_obs(id);
        if (!rst && o.ov) begin
          if (qsize(id) == 0) begin
            check($sformatf("dut%0d spurious out_valid", id), 80'(o.ov), 80'(0));
          end else begin
            e = qfront(id);
            if (!pv[id]) begin
              check($sformatf("dut%0d latency", id), 80'(cyc - e.acc), 80'(bw(id)));
            end
            check($sformatf("dut%0d bcd", id), o.bcd, e.bcd);
            check($sformatf("dut%0d neg", id), 80'(o.neg), 80'(e.neg));
            check($sformatf("dut%0d overflow", id), 80'(o.ovf), 80'(e.ovf));
            check($sformatf("dut%0d in_ready in DONE", id), 80'(o.irdy), 80'(0));
            if (o.ordy) qpop(id);
          end
        end
        pv[id] = o.ov;
      end
    end
  end

  initial begin
    obs_t o;
    int   n;
    repeat (3) @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      o = get_obs(id);
      check($sformatf("dut%0d reset in_ready", id), 80'(o.irdy), 80'(1));
      check($sformatf("dut%0d reset out_valid", id), 80'(o.ov), 80'(0));
      check($sformatf("dut%0d reset bcd", id), o.bcd, 80'(0));
      check($sformatf("dut%0d reset neg", id), 80'(o.neg), 80'(0));
      check($sformatf("dut%0d reset overflow", id), 80'(o.ovf), 80'(0));
    end
    rst = 1'b0;
    sync();

    // Default configuration: zero, full-scale unsigned, held result, signed cases.
    rdy0 = 1'b1;
    send(0, 64'h0, 1'b0, 80'h0, 1'b0, 1'b0);
    wait_idle(0);
    sync();
    rdy0 = 1'b0;
    send(0, 64'hFFFF_FFFF, 1'b0, 80'h42_9496_7295, 1'b0, 1'b0);
    n = 0;
    while (!ov0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    rdy0 = 1'b1;
    send(0, 64'hFFFF_FF85, 1'b1, 80'h123, 1'b1, 1'b0);
    send(0, 64'h8000_0000, 1'b1, 80'h21_4748_3648, 1'b1, 1'b0);
    send(0, 64'h8000_0000, 1'b0, 80'h21_4748_3648, 1'b0, 1'b0);
    send(0, 64'h0000_007B, 1'b1, 80'h123, 1'b0, 1'b0);
    wait_idle(0);

    // Eight-digit configuration: overflow boundary.
    sync();
    rdy1 = 1'b1;
    send(1, 64'd100000000, 1'b0, 80'h0, 1'b0, 1'b1);
    send(1, 64'd99999999, 1'b0, 80'h9999_9999, 1'b0, 1'b0);
    send(1, 64'hFFFF_FFFF, 1'b0, 80'h9496_7295, 1'b0, 1'b1);
    wait_idle(1);

    // Reset in the middle of a conversion discards it.
    sync();
    send(0, 64'd12345, 1'b0, 80'h1_2345, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov0) n++;
    end
    check("abort out_valid cycles", 80'(n), 80'(0));
    check("abort bcd", 80'(bcd0), 80'(0));
    check("abort neg", 80'(n0), 80'(0));
    check("abort overflow", 80'(f0), 80'(0));
    check("abort in_ready", 80'(ir0), 80'(1));
    sync();
    send(0, 64'd987654321, 1'b0, 80'h09_8765_4321, 1'b0, 1'b0);
    wait_idle(0);

    // 8-bit configuration: every value, random out_ready.
    sync();
    for (int v = 0; v < 256; v++) begin
      send(2, 64'(v), 1'b0, ref_bcd(longint'(v), int'(D2)), 1'b0, 1'b0);
    end
    wait_idle(2);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
